// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_disp_pkg;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] ANODE_ONEHOT_N(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Modulo-DIV counter that advances while en is high and pulses tick on its last count.
module scan_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // DIV=1 keeps cnt at 0, so tick simply follows en.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_mux.sv
// 4-digit common-anode display scanner for one 16-bit word.
// Optional blinking is compiled in with `define DISP_BLINK_EN.
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           data_in,
  input  logic                  load,
  input  logic                  blank,
`ifdef DISP_BLINK_EN
  input  logic                  blink,
`endif
  output logic [NUM_DIGITS-1:0] anode,
  output logic [DIGIT_W-1:0]    digit,
  output logic [1:0]            digit_idx,
  output logic                  frame_done
);
  localparam int unsigned BLINK_DIV = (BLINK_TICKS < 1) ? 1 : BLINK_TICKS;

  logic        tick;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [15:0] shadow;
  logic        loaded;
  logic        phase;
  logic        blink_dark;
  logic        dark;

  scan_tick_gen #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (tick)
  );

`ifdef DISP_BLINK_EN
  logic bc_wrap;

  scan_tick_gen #(.DIV(BLINK_DIV)) u_blink_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (tick),
    .tick (bc_wrap)
  );

  // Phase runs whether or not blink is requested, so enabling blink joins the existing rhythm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b1;
    end else if (bc_wrap) begin
      phase <= ~phase;
    end
  end

  assign blink_dark = blink && !phase;
`else
  assign phase      = (BLINK_DIV >= 1);
  assign blink_dark = !phase;
`endif

  assign idx_next = idx + 2'd1;
  assign dark     = blank || !loaded || blink_dark;

  // Outputs move only on tick edges; the tick reads the shadow as it stood before a coincident load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      loaded     <= 1'b0;
      anode      <= ANODE_OFF;
      digit      <= '0;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow <= data_in;
        loaded <= 1'b1;
      end
      if (tick) begin
        idx       <= idx_next;
        digit_idx <= idx_next;
        digit     <= shadow[DIGIT_W*idx_next +: DIGIT_W];
        anode     <= dark ? ANODE_OFF : ANODE_ONEHOT_N(idx_next);
      end
      frame_done <= tick && (idx_next == 2'd0);
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed tables, hand sequences and a random run against a tick-arithmetic model.
module tb_seg_scan_mux;
  localparam int unsigned DIV = 4;
  localparam int unsigned BT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        load;
  logic        blank;
  logic        blink;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, plus the word the display should hold.
  int          edges;
  logic [15:0] m_shadow;
  bit          m_loaded;
  bit          last_tick;
  logic [3:0]  exp_anode;
  logic [3:0]  exp_digit;
  logic [1:0]  exp_idx;
  logic        exp_fd;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] digit;
    logic [3:0] anode;
    logic       fd;
  } tick_vec_t;
  tick_vec_t vec[4];

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seg_scan_mux #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .blank      (blank),
`ifdef DISP_BLINK_EN
    .blink      (blink),
`endif
    .anode      (anode),
    .digit      (digit),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_anode", 16'(anode), 16'(exp_anode));
    chk("model_digit", 16'(digit), 16'(exp_digit));
    chk("model_idx", 16'(digit_idx), 16'(exp_idx));
    chk("model_frame_done", 16'(frame_done), 16'(exp_fd));
  endtask

  // Asserts reset between edges, checks the outputs cleared without a clock, releases before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("reset_anode", 16'(anode), 16'hF);
    chk("reset_digit", 16'(digit), 16'h0);
    chk("reset_idx", 16'(digit_idx), 16'h0);
    chk("reset_frame_done", 16'(frame_done), 16'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    edges     = 0;
    m_shadow  = 16'h0;
    m_loaded  = 0;
    exp_anode = 4'hF;
    exp_digit = 4'h0;
    exp_idx   = 2'd0;
    exp_fd    = 1'b0;
  endtask

  // Advances one clock; the model predicts the edge from tick number t = edges/DIV + 1.
  task automatic step();
    int          t;
    int          nidx;
    bit          dark;
    logic [15:0] sh;
    last_tick = ((edges % DIV) == DIV - 1);
    if (last_tick) begin
      t    = edges / DIV + 1;
      nidx = t % 4;
      dark = blank || !m_loaded;
`ifdef DISP_BLINK_EN
      if (blink && (((t - 1) / BT) % 2 == 1)) dark = 1;
`endif
      sh        = m_shadow >> (4 * nidx);
      exp_idx   = 2'(nidx);
      exp_digit = sh[3:0];
      exp_anode = dark ? 4'hF : (4'hF ^ (4'b0001 << nidx));
      exp_fd    = (nidx == 0);
    end else begin
      exp_fd = 1'b0;
    end
    if (load) begin
      m_shadow = data_in;
      m_loaded = 1;
    end
    edges++;
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic run_to_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_tick && n < 2 * DIV);
    checks++;
    if (!last_tick) begin
      errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected one within %0d", n, DIV);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    data_in = w;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    int fd_count;
    int lit;
    bit exp_lit;
    rst     = 1'b1;
    data_in = 16'h0;
    load    = 1'b0;
    blank   = 1'b0;
    blink   = 1'b0;

    vec[0] = '{idx: 2'd1, digit: 4'hC, anode: 4'b1101, fd: 1'b0};
    vec[1] = '{idx: 2'd2, digit: 4'h3, anode: 4'b1011, fd: 1'b0};
    vec[2] = '{idx: 2'd3, digit: 4'hA, anode: 4'b0111, fd: 1'b0};
    vec[3] = '{idx: 2'd0, digit: 4'h5, anode: 4'b1110, fd: 1'b1};

    // Dark scan with no word loaded.
    do_reset();
    fd_count = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("unloaded_dark", 16'(anode), 16'hF);
      if (frame_done) fd_count++;
    end
    chk("frame_done_count_40cyc", 16'(fd_count), 16'd2);

    // Load A3C5 and walk one frame against the table.
    do_reset();
    load_word(16'hA3C5);
    for (int i = 0; i < 4; i++) begin
      run_to_tick();
      chk("tbl_idx", 16'(digit_idx), 16'(vec[i].idx));
      chk("tbl_digit", 16'(digit), 16'(vec[i].digit));
      chk("tbl_anode", 16'(anode), 16'(vec[i].anode));
      chk("tbl_frame_done", 16'(frame_done), 16'(vec[i].fd));
    end
    step();
    chk("frame_done_clears", 16'(frame_done), 16'h0);

    // Load coinciding with a tick: that tick still shows the old word.
    while ((edges % DIV) != DIV - 1) step();
    load_word(16'h1234);
    chk("coincident_load_idx", 16'(digit_idx), 16'd1);
    chk("coincident_load_digit", 16'(digit), 16'hC);
    run_to_tick();
    chk("after_load_idx", 16'(digit_idx), 16'd2);
    chk("after_load_digit", 16'(digit), 16'h2);

    // Blank mid-frame, then unblank.
    step();
    blank = 1'b1;
    run_to_tick();
    chk("blank_anode", 16'(anode), 16'hF);
    chk("blank_idx", 16'(digit_idx), 16'd3);
    chk("blank_digit", 16'(digit), 16'h1);
    blank = 1'b0;
    run_to_tick();
    chk("unblank_anode", 16'(anode), 16'b1110);

    // Reset mid-frame at idx 2: word lost until reloaded.
    run_to_tick();
    run_to_tick();
    chk("pre_reset_idx", 16'(digit_idx), 16'd2);
    step();
    do_reset();
    run_to_tick();
    run_to_tick();
    chk("post_reset_dark", 16'(anode), 16'hF);
    load_word(16'h00F0);
    run_to_tick();
    run_to_tick();
    chk("reload_lit", 16'(anode), 16'b1110);

`ifdef DISP_BLINK_EN
    // Blink: two ticks lit, two dark, from a fresh reset.
    do_reset();
    blink = 1'b1;
    load_word(16'h4321);
    for (int i = 0; i < 8; i++) begin
      run_to_tick();
      exp_lit = ((i / 2) % 2) == 0;
      lit = (anode != 4'hF);
      chk("blink_pattern", 16'(lit), 16'(exp_lit));
    end
    blink = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_to_tick();
      chk("blink_off_lit", 16'(anode != 4'hF), 16'h1);
    end
`endif

    // Random traffic: loads are remembered in a queue and each shown word must match its latest entry.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
`ifdef DISP_BLINK_EN
      if ($urandom_range(0, 31) == 0) blink = ~blink;
`endif
      if (load) exp_q.push_back(data_in);
      step();
    end
    load  = 1'b0;
    blank = 1'b0;
    if (exp_q.size() > 0) begin
      for (int i = 0; i < 4; i++) run_to_tick();
      chk("random_final_word_digit", 16'(digit), 16'(exp_q[exp_q.size()-1] >> (4 * digit_idx)) & 16'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
